// File: rtl/mem_port_arbiter.sv
// Round-robin IF/LS sequencer for one memory port, one transaction in flight; accept->response >= 3 cycles.
// A memory stall holds ISSUE indefinitely, WAIT aborts after TIMEOUT cycles; requesters cannot stall responses.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                ls_req_valid,
  input  logic                ls_req_we,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic                ls_req_ready,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic [1:0]          current_state_vector,
  output logic [1:0]          error_vector
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_WAIT    = 2'b10,
    S_RESPOND = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_ls;
  logic                r_gnt_ls;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [DATA_W-1:0]   r_if_data;
  logic [DATA_W-1:0]   r_ls_data;

  logic                w_pick_ls;
  logic                w_pick_if;
  logic                w_accept;
  logic                w_done;
  logic                w_timeout;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [DATA_W-1:0]   w_rdata;

  // On a conflict the requester that did not win last time gets the port.
  assign w_pick_ls = ls_req_valid && (!if_req_valid || !r_last_ls);
  assign w_pick_if = if_req_valid && !w_pick_ls;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));
  assign w_rdata   = (mem_resp_valid && !r_we) ? mem_resp_data : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if_req_ready = w_pick_if;
        ls_req_ready = w_pick_ls;
        if (w_pick_if || w_pick_ls) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid || w_timeout) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESPOND;
        end
      end
      S_RESPOND: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_ls <= 1'b0;
      r_gnt_ls  <= 1'b0;
      r_cnt     <= '0;
      r_err     <= 2'b00;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_if_data <= '0;
      r_ls_data <= '0;
    end else begin
      if (w_accept) begin
        r_gnt_ls <= w_pick_ls;
        r_addr   <= w_pick_ls ? ls_req_addr : if_req_addr;
        r_we     <= w_pick_ls && ls_req_we;
        r_wdata  <= w_pick_ls ? ls_req_wdata : '0;
        r_wstrb  <= w_pick_ls ? ls_req_wstrb : '0;
      end
      if (r_state == S_ISSUE && mem_req_ready) r_cnt <= '0;
      else if (r_state == S_WAIT)              r_cnt <= w_cnt_inc;
      // A response landing on the timeout cycle wins; only a true abort flags bit 0.
      if (w_done) begin
        if (r_gnt_ls) r_ls_data <= w_rdata;
        else          r_if_data <= w_rdata;
        if (!mem_resp_valid) r_err[0] <= 1'b1;
      end
      if (mem_resp_valid && r_state != S_WAIT) r_err[1] <= 1'b1;
      if (r_state == S_RESPOND) r_last_ls <= r_gnt_ls;
    end
  end

  assign mem_req_valid        = (r_state == S_ISSUE);
  assign mem_req_we           = r_we;
  assign mem_req_addr         = r_addr;
  assign mem_req_wdata        = r_wdata;
  assign mem_req_wstrb        = r_wstrb;
  assign if_resp_valid        = (r_state == S_RESPOND) && !r_gnt_ls;
  assign ls_resp_valid        = (r_state == S_RESPOND) && r_gnt_ls;
  assign if_resp_data         = r_if_data;
  assign ls_resp_data         = r_ls_data;
  assign current_state_vector = r_state;
  assign error_vector         = r_err;
endmodule
